// File: rtl/taylor_pkg.sv
// Shared definitions for the taylor_poly subsystem: Q15.16 format constants
// and the requester tag that rides alongside each engine sample.
package taylor_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int FRAC_BITS  = 16;

    localparam logic [DATA_WIDTH-1:0] Q_ZERO  = 32'h0000_0000;
    localparam logic [DATA_WIDTH-1:0] Q_HALF  = 32'h0000_8000;
    localparam logic [DATA_WIDTH-1:0] Q_ONE   = 32'h0001_0000;
    localparam logic [DATA_WIDTH-1:0] Q_TWO   = 32'h0002_0000;
    localparam logic [DATA_WIDTH-1:0] Q_THREE = 32'h0003_0000;

    // Sized for the largest supported requester count (8).
    localparam int MAX_REQ   = 8;
    localparam int TAG_IDX_W = $clog2(MAX_REQ);

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } tag_t;

    localparam tag_t TAG_NONE = '{valid: 1'b0, idx: '0};

endpackage

// File: rtl/taylor_rr_arb.sv
// N-way round-robin arbiter: combinational grant searching from rr_q,
// pointer advances to one past the winner on every grant.
module taylor_rr_arb #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] eligible,
    output logic [N_REQ-1:0] grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] rr_q, rr_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int off = 0; off < N_REQ; off++) begin
            int cand;
            cand = int'(rr_q) + off;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (!grant_valid && eligible[IDX_W'(cand)]) begin
                grant_valid              = 1'b1;
                grant_idx                = IDX_W'(cand);
                grant[IDX_W'(cand)]      = 1'b1;
            end
        end
        rr_d = rr_q;
        if (grant_valid) begin
            rr_d = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_q <= '0;
        else        rr_q <= rr_d;
    end

endmodule

// File: rtl/taylor_poly_arbiter.sv
// Round-robin front-end sharing one pipelined taylor_poly engine between N_REQ
// requesters; a tag pipeline routes each engine result back to its issuer.
module taylor_poly_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 5,
    parameter int MAX_OUT    = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_x,
    output logic [N_REQ-1:0]            req_ready,
    output logic [N_REQ-1:0]            resp_valid,
    output logic [N_REQ*DATA_WIDTH-1:0] resp_y,
    input  logic                        flush,
    output logic                        idle,
    output logic                        err_tag,
    output logic                        eng_valid_in,
    output logic [DATA_WIDTH-1:0]       eng_x_in,
    input  logic                        eng_valid_out,
    input  logic [DATA_WIDTH-1:0]       eng_y_out
);
    import taylor_pkg::*;

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = 4;

    logic [N_REQ-1:0]            eligible, grant;
    logic                        grant_valid;
    logic [IDX_W-1:0]            grant_idx, out_idx;
    logic                        eng_valid_in_q, eng_valid_in_d;
    logic [DATA_WIDTH-1:0]       eng_x_in_q, eng_x_in_d;
    tag_t                        issue_tag_q, issue_tag_d, out_tag;
    tag_t                        tag_sr_q [LATENCY];
    tag_t                        tag_sr_d [LATENCY];
    logic [CNT_W-1:0]            cnt_q [N_REQ];
    logic [CNT_W-1:0]            cnt_d [N_REQ];
    logic [N_REQ-1:0]            resp_valid_q, resp_valid_d, dec_q, dec_d;
    logic [N_REQ*DATA_WIDTH-1:0] resp_y_q, resp_y_d;
    logic                        err_tag_q, err_tag_d;

    // Gating with rst_n keeps req_ready low while reset is held.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = rst_n && req_valid[i] && !flush && (cnt_q[i] < CNT_W'(MAX_OUT));
        end
    end

    taylor_rr_arb #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .eligible    (eligible),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // issue_tag_q sits beside eng_valid_in; tag_sr_q[LATENCY-1] then lines up with eng_valid_out.
    always_comb begin
        eng_valid_in_d = grant_valid;
        eng_x_in_d     = eng_x_in_q;
        issue_tag_d    = TAG_NONE;
        if (grant_valid) begin
            eng_x_in_d      = req_x[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            issue_tag_d.valid = 1'b1;
            issue_tag_d.idx   = TAG_IDX_W'(grant_idx);
        end
        tag_sr_d[0] = issue_tag_q;
        for (int s = 1; s < LATENCY; s++) tag_sr_d[s] = tag_sr_q[s-1];
    end

    always_comb begin
        out_tag      = tag_sr_q[LATENCY-1];
        out_idx      = IDX_W'(out_tag.idx);
        resp_valid_d = '0;
        dec_d        = '0;
        resp_y_d     = resp_y_q;
        err_tag_d    = err_tag_q;
        if (eng_valid_out != out_tag.valid) err_tag_d = 1'b1;
        // A valid tag always retires its slot, even when the result is dropped.
        if (out_tag.valid) begin
            dec_d[out_idx] = 1'b1;
            if (eng_valid_out) begin
                resp_valid_d[out_idx]                              = 1'b1;
                resp_y_d[int'(out_idx)*DATA_WIDTH +: DATA_WIDTH] = eng_y_out;
            end
        end
    end

    always_comb begin
        idle = !eng_valid_in_q;
        for (int i = 0; i < N_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (grant[i] && !dec_q[i])      cnt_d[i] = cnt_q[i] + 1'b1;
            else if (!grant[i] && dec_q[i]) cnt_d[i] = cnt_q[i] - 1'b1;
            if (cnt_q[i] != '0) idle = 1'b0;
        end
    end

    // NOTE: the tag pipeline is reset (not left as plain storage) so a reset mid-flight cannot release stale tags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_valid_in_q <= 1'b0;
            eng_x_in_q     <= '0;
            issue_tag_q    <= TAG_NONE;
            resp_valid_q   <= '0;
            dec_q          <= '0;
            resp_y_q       <= '0;
            err_tag_q      <= 1'b0;
            for (int s = 0; s < LATENCY; s++) tag_sr_q[s] <= TAG_NONE;
            for (int i = 0; i < N_REQ; i++)   cnt_q[i]    <= '0;
        end else begin
            eng_valid_in_q <= eng_valid_in_d;
            eng_x_in_q     <= eng_x_in_d;
            issue_tag_q    <= issue_tag_d;
            resp_valid_q   <= resp_valid_d;
            dec_q          <= dec_d;
            resp_y_q       <= resp_y_d;
            err_tag_q      <= err_tag_d;
            for (int s = 0; s < LATENCY; s++) tag_sr_q[s] <= tag_sr_d[s];
            for (int i = 0; i < N_REQ; i++)   cnt_q[i]    <= cnt_d[i];
        end
    end

    assign req_ready    = grant;
    assign resp_valid   = resp_valid_q;
    assign resp_y       = resp_y_q;
    assign err_tag      = err_tag_q;
    assign eng_valid_in = eng_valid_in_q;
    assign eng_x_in     = eng_x_in_q;

endmodule
